// File: rtl/fb_pkg.sv
// Framebuffer shared definitions: port-A arbiter state encoding and the RAM
// geometry shared by the RAM instance, the arbiter and the VGA reader.
package fb_pkg;

  localparam int FB_DATA = 18;
  localparam int FB_ADDR = 14;
  localparam int FB_SIZE = 12288;

  localparam logic [FB_DATA-1:0] FB_CLEAR_VAL = '0;

  typedef enum logic {
    FB_IDLE  = 1'b0,
    FB_CLEAR = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Port-A bundle of the framebuffer arbiter: two requesters, the clear
// control, and the RAM port-A pins.
interface fb_port_arbiter_if #(
  parameter int DATA = 18,
  parameter int ADDR = 14
);

  logic            clear_start;
  logic            clear_busy;

  logic            r0_req;
  logic            r0_we;
  logic [ADDR-1:0] r0_addr;
  logic [DATA-1:0] r0_wdata;
  logic            r0_gnt;
  logic            r0_rvalid;
  logic [DATA-1:0] r0_rdata;

  logic            r1_req;
  logic            r1_we;
  logic [ADDR-1:0] r1_addr;
  logic [DATA-1:0] r1_wdata;
  logic            r1_gnt;
  logic            r1_rvalid;
  logic [DATA-1:0] r1_rdata;

  logic            mem_we;
  logic [ADDR-1:0] mem_addr;
  logic [DATA-1:0] mem_din;
  logic [DATA-1:0] mem_dout;

  // Arbiter side.
  modport slave (
    input  clear_start,
    output clear_busy,
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  // Requesters plus RAM side.
  modport master (
    output clear_start,
    input  clear_busy,
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_we, mem_addr, mem_din,
    output mem_dout
  );

endinterface

// File: rtl/fb_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer names the last winner, so the other
// requester wins the next contention; reset value 1 lets req0 win first.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en && !rst) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_ptr ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b1;
    end else if (|o_gnt) begin
      r_ptr <= o_gnt[1];
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Framebuffer RAM port-A arbiter: round-robin CPU/painter sharing with
// one-cycle read return, plus a full-RAM clear sweep that locks requesters out.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int              DATA      = FB_DATA,
  parameter int              ADDR      = FB_ADDR,
  parameter int              SIZE      = FB_SIZE,
  parameter logic [DATA-1:0] CLEAR_VAL = FB_CLEAR_VAL
) (
  input logic              clk,
  input logic              rst,
  fb_port_arbiter_if.slave bus
);

  fb_state_e       r_state, w_state_nxt;
  logic [ADDR-1:0] r_cnt, w_cnt_nxt;
  logic            r_rvalid0, r_rvalid1;
  logic            r_oor;
  logic [ADDR-1:0] r_last_addr;

  logic [1:0]      w_gnt;
  logic            w_en;
  logic            w_sel_we;
  logic [ADDR-1:0] w_sel_addr;
  logic [DATA-1:0] w_sel_din;
  logic            w_in_range;
  logic            w_mem_we;
  logic [ADDR-1:0] w_mem_addr;
  logic [DATA-1:0] w_mem_din;

  assign w_en = (r_state == FB_IDLE);

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_en),
    .i_req ({bus.r1_req, bus.r0_req}),
    .o_gnt (w_gnt)
  );

  assign w_sel_we   = w_gnt[1] ? bus.r1_we    : bus.r0_we;
  assign w_sel_addr = w_gnt[1] ? bus.r1_addr  : bus.r0_addr;
  assign w_sel_din  = w_gnt[1] ? bus.r1_wdata : bus.r0_wdata;
  assign w_in_range = ({{(32-ADDR){1'b0}}, w_sel_addr} < 32'(SIZE));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_last_addr;
    w_mem_din   = w_sel_din;
    case (r_state)
      FB_IDLE: begin
        if (|w_gnt) begin
          w_mem_addr = w_sel_addr;
          w_mem_we   = w_sel_we & w_in_range;
        end
        if (bus.clear_start) begin
          w_state_nxt = FB_CLEAR;
        end
      end
      FB_CLEAR: begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_cnt;
        w_mem_din  = CLEAR_VAL;
        if (r_cnt == ADDR'(SIZE-1)) begin
          w_state_nxt = FB_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR'(1);
        end
      end
      default: w_state_nxt = FB_IDLE;
    endcase
    if (rst) begin
      w_mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FB_IDLE;
      r_cnt       <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_oor       <= 1'b0;
      r_last_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rvalid0   <= w_gnt[0] & ~bus.r0_we;
      r_rvalid1   <= w_gnt[1] & ~bus.r1_we;
      r_last_addr <= w_mem_addr;
      // Out-of-range reads return zero rather than whatever the RAM aliases to.
      if (|w_gnt) begin
        r_oor <= ~w_in_range;
      end
    end
  end

  assign bus.clear_busy = (r_state == FB_CLEAR);
  assign bus.r0_gnt     = w_gnt[0];
  assign bus.r1_gnt     = w_gnt[1];
  assign bus.r0_rvalid  = r_rvalid0;
  assign bus.r1_rvalid  = r_rvalid1;
  assign bus.r0_rdata   = r_oor ? '0 : bus.mem_dout;
  assign bus.r1_rdata   = r_oor ? '0 : bus.mem_dout;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_din    = w_mem_din;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural read-first port-A RAM.
module tb_fb_port_arbiter;

  localparam int DATA = 18;
  localparam int ADDR = 14;
  localparam int SIZE = 12288;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  fb_port_arbiter_if #(.DATA(DATA), .ADDR(ADDR)) bus ();

  fb_port_arbiter #(.DATA(DATA), .ADDR(ADDR), .SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DATA-1:0] ram [0:SIZE-1];

  always @(posedge clk) begin
    if (bus.mem_we && (32'(bus.mem_addr) < SIZE)) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= (32'(bus.mem_addr) < SIZE) ? ram[bus.mem_addr] : '0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle_reqs();
    bus.r0_req = 1'b0; bus.r0_we = 1'b0;
    bus.r1_req = 1'b0; bus.r1_we = 1'b0;
  endtask

  // One cycle from one requester; checks the grant and the RAM write strobe.
  task automatic access(input bit rq, input bit we, input logic [ADDR-1:0] a,
                        input logic [DATA-1:0] d, input bit exp_we, input string tag);
    @(negedge clk);
    idle_reqs();
    if (rq) begin
      bus.r1_req = 1'b1; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
    end else begin
      bus.r0_req = 1'b1; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
    end
    #1;
    chk({tag, "_gnt"},   32'(rq ? bus.r1_gnt : bus.r0_gnt), 32'(1));
    chk({tag, "_ogn"},   32'(rq ? bus.r0_gnt : bus.r1_gnt), 32'(0));
    chk({tag, "_we"},    32'(bus.mem_we), 32'(exp_we));
    chk({tag, "_maddr"}, 32'(bus.mem_addr), 32'(a));
  endtask

  task automatic rd_chk(input bit rq, input logic [ADDR-1:0] a,
                        input logic [DATA-1:0] exp, input string tag);
    access(rq, 1'b0, a, '0, 1'b0, tag);
    @(negedge clk);
    idle_reqs();
    #1;
    chk({tag, "_rv"}, 32'(rq ? bus.r1_rvalid : bus.r0_rvalid), 32'(1));
    chk({tag, "_rd"}, 32'(rq ? bus.r1_rdata : bus.r0_rdata), 32'(exp));
  endtask

  initial begin
    int c0, c1, busy_cnt, bad_gnt;
    n_pass = 0; n_total = 0;
    rst = 1'b1;
    bus.clear_start = 1'b0;
    bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_addr = '0; bus.r1_wdata = '0;
    idle_reqs();

    // Reset: grants and writes suppressed, registered flags low.
    @(negedge clk);
    bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r1_req = 1'b1;
    #1;
    chk("rst_gnt0",  32'(bus.r0_gnt), 32'(0));
    chk("rst_gnt1",  32'(bus.r1_gnt), 32'(0));
    chk("rst_memwe", 32'(bus.mem_we), 32'(0));
    chk("rst_busy",  32'(bus.clear_busy), 32'(0));
    chk("rst_rv0",   32'(bus.r0_rvalid), 32'(0));
    chk("rst_rv1",   32'(bus.r1_rvalid), 32'(0));
    @(negedge clk);
    idle_reqs();
    rst = 1'b0;

    // Write then back-to-back reads of addr 5.
    access(1'b0, 1'b1, 14'd5, 18'h2A, 1'b1, "w5");
    chk("w5_din", 32'(bus.mem_din), 32'h2A);
    access(1'b0, 1'b0, 14'd5, '0, 1'b0, "r5a");
    chk("wr_no_rv", 32'(bus.r0_rvalid), 32'(0));
    access(1'b0, 1'b0, 14'd5, '0, 1'b0, "r5b");
    chk("r5a_rv",  32'(bus.r0_rvalid), 32'(1));
    chk("r5a_rd",  32'(bus.r0_rdata), 32'h2A);
    chk("r5a_rv1", 32'(bus.r1_rvalid), 32'(0));
    @(negedge clk); idle_reqs(); #1;
    chk("r5b_rv",  32'(bus.r0_rvalid), 32'(1));
    chk("r5b_rd",  32'(bus.r0_rdata), 32'h2A);
    @(negedge clk); #1;
    chk("r5_rv_drop", 32'(bus.r0_rvalid), 32'(0));

    // Contention from reset: alternate grants starting with req0.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 14'd5;
      bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 14'd5;
      #1;
      chk("cont_g0", 32'(bus.r0_gnt), 32'(i % 2 == 0));
      chk("cont_g1", 32'(bus.r1_gnt), 32'(i % 2 == 1));
      chk("cont_rv0", 32'(bus.r0_rvalid), 32'(i > 0 && (i % 2 == 1)));
      c0 += int'(bus.r0_gnt);
      c1 += int'(bus.r1_gnt);
    end
    chk("cont_n0", 32'(c0), 32'(5));
    chk("cont_n1", 32'(c1), 32'(5));

    // Out-of-range write dropped, out-of-range read returns zero.
    access(1'b0, 1'b1, 14'd0, 18'h111, 1'b1, "w0");
    access(1'b1, 1'b1, 14'd12288, 18'h3FFFF, 1'b0, "woor");
    access(1'b1, 1'b0, 14'd12288, '0, 1'b0, "roor");
    access(1'b1, 1'b0, 14'd0, '0, 1'b0, "r0a");
    chk("oor_rv", 32'(bus.r1_rvalid), 32'(1));
    chk("oor_rd", 32'(bus.r1_rdata), 32'(0));
    @(negedge clk); idle_reqs(); #1;
    chk("a0_rv", 32'(bus.r1_rvalid), 32'(1));
    chk("a0_rd", 32'(bus.r1_rdata), 32'h111);

    // Full clear, with a read granted in the clear_start cycle.
    access(1'b0, 1'b1, 14'd100, 18'h2, 1'b1, "w100");
    access(1'b1, 1'b1, 14'd12287, 18'h3FFFE, 1'b1, "wtop");
    access(1'b0, 1'b1, 14'd7, 18'h77, 1'b1, "w7");
    access(1'b0, 1'b0, 14'd7, '0, 1'b0, "r7cs");
    bus.clear_start = 1'b1;
    #1;
    chk("cs_gnt0", 32'(bus.r0_gnt), 32'(1));
    @(negedge clk);
    bus.clear_start = 1'b0;
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 14'd100;
    #1;
    chk("clr_busy1", 32'(bus.clear_busy), 32'(1));
    chk("clr_rv7",   32'(bus.r0_rvalid), 32'(1));
    chk("clr_rd7",   32'(bus.r0_rdata), 32'h77);
    chk("clr_nogn",  32'(bus.r0_gnt), 32'(0));
    busy_cnt = 1; bad_gnt = 0;
    for (int k = 0; k < 13000; k++) begin
      @(negedge clk);
      bus.clear_start = (k == 100);
      #1;
      if (!bus.clear_busy) break;
      busy_cnt++;
      if (bus.r0_gnt || bus.r1_gnt) bad_gnt++;
    end
    chk("clr_len",    32'(busy_cnt), 32'(SIZE));
    chk("clr_no_gnt", 32'(bad_gnt), 32'(0));
    chk("clr_held",   32'(bus.r0_gnt), 32'(1));
    @(negedge clk); idle_reqs(); #1;
    chk("clr_rv100", 32'(bus.r0_rvalid), 32'(1));
    chk("clr_rd100", 32'(bus.r0_rdata), 32'(0));
    rd_chk(1'b0, 14'd0, '0, "clr_a0");
    rd_chk(1'b1, 14'd12287, '0, "clr_top");

    // Reset while the sweep is at counter 50.
    access(1'b0, 1'b1, 14'd49, 18'h49, 1'b1, "w49");
    access(1'b0, 1'b1, 14'd50, 18'h50, 1'b1, "w50");
    access(1'b0, 1'b1, 14'd51, 18'h51, 1'b1, "w51");
    @(negedge clk); idle_reqs(); bus.clear_start = 1'b1;
    @(negedge clk); bus.clear_start = 1'b0;
    repeat (50) @(negedge clk);
    #1;
    chk("mid_busy", 32'(bus.clear_busy), 32'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.clear_busy), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 14'd49;
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 14'd49;
    #1;
    chk("mid_g0", 32'(bus.r0_gnt), 32'(1));
    chk("mid_g1", 32'(bus.r1_gnt), 32'(0));
    rd_chk(1'b0, 14'd49, '0, "mid_a49");
    rd_chk(1'b0, 14'd50, 18'h50, "mid_a50");
    rd_chk(1'b1, 14'd51, 18'h51, "mid_a51");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares port A of the framebuffer dual-port block RAM between two requesters: req0 is the CPU bus and req1 is the painter/fill engine.
- Round-robin arbitration, one access per cycle; read data returns with a one-cycle latency and a per-requester valid flag.
- Built-in clear sequencer sweeps the whole RAM to CLEAR_VAL on command; requesters are locked out while it runs.
- Port B (VGA scan-out) is untouched by this block.

Parameters:
- DATA, 18, RAM word width.
- ADDR, 14, RAM address width.
- SIZE, 12288, number of RAM words; valid addresses are 0..SIZE-1.
- CLEAR_VAL, 0, word written by the clear sweep (DATA bits).

Ports:
- clk  in  1  single system clock; RAM port A is clocked by the same clk.
- rst  in  1  asynchronous, active-high reset.
- clear_start  in  1  one-cycle pulse that requests a full-RAM clear.
- clear_busy  out  1  high while the clear sweep is running.
- r0_req / r1_req  in  1  access request; held until granted.
- r0_we / r1_we  in  1  1 = write, 0 = read.
- r0_addr / r1_addr  in  ADDR  access address.
- r0_wdata / r1_wdata  in  DATA  write data.
- r0_gnt / r1_gnt  out  1  combinational grant; the access completes at the next posedge.
- r0_rvalid / r1_rvalid  out  1  registered; high one cycle after a granted read.
- r0_rdata / r1_rdata  out  DATA  read data; meaningful only while the matching rvalid is high.
- mem_we  out  1  to RAM port A (wea).
- mem_addr  out  ADDR  to RAM port A (addra).
- mem_din  out  DATA  to RAM port A (dina).
- mem_dout  in  DATA  from RAM port A (douta); valid one cycle after the address is presented.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- States: IDLE and CLEAR.
- Reset values:
  - state = IDLE, clear counter = 0, rr pointer = 1 (so req0 wins the first contention).
  - clear_busy = 0, both rvalid = 0, the oor flag = 0.
  - Both gnt outputs and mem_we are forced to 0 while rst is high.
- Arbitration in IDLE (combinational):
  - Only one request: that requester is granted.
  - Both requesting: grant goes to the requester that is not named by the rr pointer.
  - On any grant, the rr pointer is updated at the clock edge to the granted index.
  - No request: no grant, mem_we = 0, mem_addr holds its last value (don't-care).
- Granted access:
  - mem_addr, mem_we and mem_din are driven from the granted requester in the same cycle.
  - mem_we = we AND (addr < SIZE). An out-of-range write is granted but dropped.
- Read return:
  - A granted read sets the matching rvalid high in the next cycle only.
  - rdata = mem_dout, or 0 if the registered oor flag (addr >= SIZE) is set.
  - Back-to-back reads from the same requester give rvalid on consecutive cycles.
  - A write never raises rvalid.
- Clear start:
  - clear_start is sampled only in IDLE. Arbitration in that same cycle proceeds normally.
  - CLEAR is entered at the next edge.
- CLEAR state:
  - Each cycle: mem_we = 1, mem_addr = counter, mem_din = CLEAR_VAL; then counter += 1.
  - At counter = SIZE-1 the write is issued and the block returns to IDLE with the counter reset to 0.
  - clear_busy is high for exactly SIZE cycles.
  - No grants are issued during CLEAR. Pending requests wait; they are not lost because req is held by the requester.
  - clear_start is ignored while in CLEAR.
- Reads pending at clear entry: a read granted in the clear_start cycle still returns its rvalid and data in the first CLEAR cycle.
- Reset mid-clear: immediately IDLE, counter 0, busy 0. The RAM is left partially cleared.
- Counter width: ADDR bits; SIZE must satisfy SIZE <= 2^ADDR.

Decomposition:
- Shared package fb_pkg holds:
  - the state encoding (FB_IDLE, FB_CLEAR);
  - the DATA/ADDR/SIZE defaults shared with the RAM instance and the VGA reader.
- One sub-module: rr_arbiter2 (2-way round-robin). Inputs req[1:0]; outputs gnt[1:0]; owns the rr pointer register and exposes an enable input that is tied low during CLEAR.

Test Plan:
- Single write then read: r0 writes addr 5 = 0x2A, then r0 reads addr 5 → r0_gnt is high each cycle; r0_rvalid rises one cycle after the read grant with rdata = 0x2A; r1_rvalid stays 0.
- Contention: r0 and r1 request continuously from reset → grants go 0,1,0,1…; each requester gets exactly 5 of 10 cycles.
- Out-of-range: r1 writes 0x3FFFF to addr 12288 → granted with mem_we = 0. A following read of addr 12288 returns rdata = 0 with rvalid = 1. A read of addr 0 is unchanged.
- Clear: preload addr 0, 100 and 12287 with nonzero data, pulse clear_start → clear_busy is high for 12288 cycles with no grants; afterwards all three addresses read 0; an r0 request held during the clear is granted on the first IDLE cycle.
- Reset mid-clear: assert rst at counter 50 → clear_busy drops immediately; after release, addr 49 reads 0 and addr 51 keeps its preload; normal arbitration resumes with req0 winning first.
- Read at clear boundary: r0 reads addr 7 in the clear_start cycle → r0_rvalid is high in the first CLEAR cycle with the pre-clear data.
